// File: rtl/sum_accum_pkg.sv
// Shared types and helpers for the accumulating bin memory.
// Holds the FSM state encoding and a width-generic saturating adder.
package sum_accum_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Widest bin sum the saturating adder supports.
    localparam int SAT_MAX_W = 64;

    localparam logic [SAT_MAX_W:0] SAT_ONE = {{SAT_MAX_W{1'b0}}, 1'b1};

    // Adds two unsigned values and clamps the result at 2^width-1.
    // The clamped output reports whether the clamp was applied.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input  logic [SAT_MAX_W-1:0] a,
        input  logic [SAT_MAX_W-1:0] b,
        input  int                   width,
        output logic                 clamped
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum     = {1'b0, a} + {1'b0, b};
        lim     = (SAT_ONE << width) - SAT_ONE;
        clamped = (sum > lim);
        if (clamped) begin
            sat_add = lim[SAT_MAX_W-1:0];
        end else begin
            sat_add = sum[SAT_MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sum_accum_ram.sv
// Bin storage for the accumulating memory: DEPTH x ACC_WIDTH array.
// The read-modify-write side reads the accepted bin and writes back the
// S1 or sweep value on the same edge, read-first. A second synchronous
// port serves the readout side. The array itself is never reset.
module sum_accum_ram #(
    parameter int ACC_WIDTH  = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [ACC_WIDTH-1:0]  i_wr_data,
    input  logic                  i_rmw_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rmw_rd_addr,
    output logic [ACC_WIDTH-1:0]  o_rmw_rd_data,
    input  logic                  i_out_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_out_rd_addr,
    output logic [ACC_WIDTH-1:0]  o_out_rd_data
);

    logic [ACC_WIDTH-1:0] r_mem [DEPTH];
    logic [ACC_WIDTH-1:0] r_rmw_q;
    logic [ACC_WIDTH-1:0] r_out_q;

    // Pipeline side: write-back plus the S0 read, which sees the pre-write value.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rmw_rd_en) begin
            r_rmw_q <= r_mem[i_rmw_rd_addr];
        end
    end

    // Readout side: holds its last value while no read is requested.
    always_ff @(posedge clk) begin
        if (i_out_rd_en) begin
            r_out_q <= r_mem[i_out_rd_addr];
        end
    end

    assign o_rmw_rd_data = r_rmw_q;
    assign o_out_rd_data = r_out_q;

endmodule

// File: rtl/sum_accum_sram.sv
// Accumulating bin memory: each accepted sample is added into its bin
// through a two-stage read-modify-write pipeline with S1->S0 forwarding,
// a second readout port, and a hardware clear sweep.
// Optional feature macro: SUM_ACCUM_SAT_EN selects clamping sums with a
// sticky o_sat flag; without it sums wrap and o_sat is tied low.
module sum_accum_sram
    import sum_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    output logic                  o_busy,
    input  logic                  i_acc_valid,
    output logic                  o_acc_ready,
    input  logic [ADDR_WIDTH-1:0] i_acc_addr,
    input  logic [DATA_WIDTH-1:0] i_acc_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_valid,
    output logic [ACC_WIDTH-1:0]  o_rd_data,
    output logic                  o_sat
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN  = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_sweep_addr;

    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_fwd_valid;
    logic [ACC_WIDTH-1:0]  r_fwd_data;

    logic                  r_rd_valid;
    logic                  r_rd_zero;

    logic                  w_clear_start;
    logic                  w_acc_in_range;
    logic                  w_rd_in_range;
    logic                  w_s0_take;
    logic                  w_s1_hit;
    logic [ACC_WIDTH-1:0]  w_old;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ACC_WIDTH-1:0]  w_wr_data;
    logic [ACC_WIDTH-1:0]  w_rmw_rd_data;
    logic [ACC_WIDTH-1:0]  w_out_rd_data;

    assign o_busy      = (r_state == CLEAR);
    assign o_acc_ready = (r_state == RUN);

    // A clear only starts from RUN; requests during a sweep are ignored.
    assign w_clear_start  = (r_state == RUN) && i_clear;
    assign w_acc_in_range = ({1'b0, i_acc_addr} < DEPTH_EXT);
    assign w_rd_in_range  = ({1'b0, i_rd_addr} < DEPTH_EXT);

    // Requests accepted in the clear cycle or aimed past the last bin never enter S1.
    assign w_s0_take = i_acc_valid && o_acc_ready && w_acc_in_range && !i_clear;
    assign w_s1_hit  = r_s1_valid && (r_s1_addr == i_acc_addr);

    // The RAM read taken in S0 is stale when S1 was writing the same bin.
    assign w_old = r_fwd_valid ? r_fwd_data : w_rmw_rd_data;

`ifdef SUM_ACCUM_SAT_EN
    logic w_clamp;
    logic r_sat;

    // Clamping adder for S1; the clamped value is also what gets forwarded.
    always_comb begin
        w_clamp = 1'b0;
        w_sum   = ACC_WIDTH'(sat_add(SAT_MAX_W'(w_old), SAT_MAX_W'(r_s1_data),
                                     ACC_WIDTH, w_clamp));
    end

    // Sticky saturation flag, dropped when a sweep begins.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sat <= 1'b0;
        end else if (w_clear_start) begin
            r_sat <= 1'b0;
        end else if (r_s1_valid && w_clamp) begin
            r_sat <= 1'b1;
        end
    end

    assign o_sat = r_sat;
`else
    // Wrapping adder for S1.
    always_comb begin
        w_sum = w_old + ACC_WIDTH'(r_s1_data);
    end

    assign o_sat = 1'b0;
`endif

    // Write port owner: the sweep writes zeros in CLEAR, S1 writes sums in RUN.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_s1_addr;
        w_wr_data = w_sum;
        if (r_state == CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_sweep_addr;
            w_wr_data = '0;
        end else if (r_s1_valid) begin
            w_wr_en = 1'b1;
        end
    end

    // Control FSM: sweep one bin per cycle in CLEAR, then accumulate in RUN.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= CLEAR;
            r_sweep_addr <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_sweep_addr == LAST_BIN) begin
                        r_state      <= RUN;
                        r_sweep_addr <= '0;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + 1'b1;
                    end
                end
                RUN: begin
                    if (i_clear) begin
                        r_state      <= CLEAR;
                        r_sweep_addr <= '0;
                    end
                end
                default: begin
                    r_state      <= CLEAR;
                    r_sweep_addr <= '0;
                end
            endcase
        end
    end

    // S0 -> S1 register stage, capturing the forwarded sum on a same-bin hit.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_data   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_s1_valid <= w_s0_take;
            if (w_s0_take) begin
                r_s1_addr   <= i_acc_addr;
                r_s1_data   <= i_acc_data;
                r_fwd_valid <= w_s1_hit;
                r_fwd_data  <= w_sum;
            end
        end
    end

    // Readout handshake; out-of-range reads are remembered so they return zero.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_zero <= !w_rd_in_range;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_zero ? '0 : w_out_rd_data;

    sum_accum_ram #(
        .ACC_WIDTH  (ACC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk           (clk),
        .i_wr_en       (w_wr_en),
        .i_wr_addr     (w_wr_addr),
        .i_wr_data     (w_wr_data),
        .i_rmw_rd_en   (w_s0_take),
        .i_rmw_rd_addr (i_acc_addr),
        .o_rmw_rd_data (w_rmw_rd_data),
        .i_out_rd_en   (i_rd_en && w_rd_in_range),
        .i_out_rd_addr (i_rd_addr),
        .o_out_rd_data (w_out_rd_data)
    );

endmodule

// File: tb/tb_sum_accum_sram.sv
// Directed bench for sum_accum_sram: a default-size instance plus a small
// 8-bit-sum instance with DEPTH below 2^ADDR_WIDTH. Read results are
// predicted into per-instance queues when the read is issued and compared
// when o_rd_valid appears. Expectations follow SUM_ACCUM_SAT_EN.
module tb_sum_accum_sram;

    logic        clk;
    logic        i_rst_n;

    logic        i_clear;
    logic        i_acc_valid;
    logic [6:0]  i_acc_addr;
    logic [7:0]  i_acc_data;
    logic        i_rd_en;
    logic [6:0]  i_rd_addr;
    logic        o_busy;
    logic        o_acc_ready;
    logic        o_rd_valid;
    logic [15:0] o_rd_data;
    logic        o_sat;

    logic        s_clear;
    logic        s_acc_valid;
    logic [2:0]  s_acc_addr;
    logic [7:0]  s_acc_data;
    logic        s_rd_en;
    logic [2:0]  s_rd_addr;
    logic        s_busy;
    logic        s_acc_ready;
    logic        s_rd_valid;
    logic [7:0]  s_rd_data;
    logic        s_sat;

    int checks   = 0;
    int failures = 0;
    int qMain[$];
    int qSmall[$];
    int busyLen;

`ifdef SUM_ACCUM_SAT_EN
    localparam int SMALL_SUM = 255;
    localparam int SMALL_SAT = 1;
`else
    localparam int SMALL_SUM = 44;
    localparam int SMALL_SAT = 0;
`endif

    sum_accum_sram dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (i_clear),
        .o_busy      (o_busy),
        .i_acc_valid (i_acc_valid),
        .o_acc_ready (o_acc_ready),
        .i_acc_addr  (i_acc_addr),
        .i_acc_data  (i_acc_data),
        .i_rd_en     (i_rd_en),
        .i_rd_addr   (i_rd_addr),
        .o_rd_valid  (o_rd_valid),
        .o_rd_data   (o_rd_data),
        .o_sat       (o_sat)
    );

    sum_accum_sram #(
        .DATA_WIDTH (8),
        .ACC_WIDTH  (8),
        .ADDR_WIDTH (3),
        .DEPTH      (6)
    ) dutSmall (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (s_clear),
        .o_busy      (s_busy),
        .i_acc_valid (s_acc_valid),
        .o_acc_ready (s_acc_ready),
        .i_acc_addr  (s_acc_addr),
        .i_acc_data  (s_acc_data),
        .i_rd_en     (s_rd_en),
        .i_rd_addr   (s_rd_addr),
        .o_rd_valid  (s_rd_valid),
        .o_rd_data   (s_rd_data),
        .o_sat       (s_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard compare for the default instance.
    always @(negedge clk) begin
        if (o_rd_valid) begin
            checkEq("main_rd_data", 32'(o_rd_data), (qMain.size() > 0) ? 32'(qMain.pop_front()) : 32'hFFFF_FFFF);
        end
    end

    // Scoreboard compare for the small instance.
    always @(negedge clk) begin
        if (s_rd_valid) begin
            checkEq("small_rd_data", 32'(s_rd_data), (qSmall.size() > 0) ? 32'(qSmall.pop_front()) : 32'hFFFF_FFFF);
        end
    end

    task automatic quiet();
        i_clear = 1'b0; i_acc_valid = 1'b0; i_acc_addr = '0; i_acc_data = '0;
        i_rd_en = 1'b0; i_rd_addr = '0;
    endtask

    task automatic sQuiet();
        s_clear = 1'b0; s_acc_valid = 1'b0; s_acc_addr = '0; s_acc_data = '0;
        s_rd_en = 1'b0; s_rd_addr = '0;
    endtask

    // One clock cycle of stimulus on the default instance.
    task automatic cyc(input logic clr, input logic av, input int aa, input int ad,
                       input logic re, input int ra, input int rexp);
        i_clear = clr; i_acc_valid = av; i_acc_addr = 7'(aa); i_acc_data = 8'(ad);
        i_rd_en = re; i_rd_addr = 7'(ra);
        if (re) qMain.push_back(rexp);
        @(posedge clk); #1;
    endtask

    task automatic idle();            cyc(0, 0, 0, 0, 0, 0, 0);    endtask
    task automatic acc(input int a, input int d); cyc(0, 1, a, d, 0, 0, 0); endtask
    task automatic rd(input int a, input int e);  cyc(0, 0, 0, 0, 1, a, e); endtask

    // One clock cycle of stimulus on the small instance.
    task automatic sCyc(input logic clr, input logic av, input int aa, input int ad,
                        input logic re, input int ra, input int rexp);
        s_clear = clr; s_acc_valid = av; s_acc_addr = 3'(aa); s_acc_data = 8'(ad);
        s_rd_en = re; s_rd_addr = 3'(ra);
        if (re) qSmall.push_back(rexp);
        @(posedge clk); #1;
    endtask

    // Counts cycles with o_busy high, bounded so a stuck sweep still ends.
    task automatic countBusy(output int n);
        quiet();
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!o_busy) break;
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkEq({tag, "_busy"},     32'(o_busy),      1);
        checkEq({tag, "_ready"},    32'(o_acc_ready), 0);
        checkEq({tag, "_rd_valid"}, 32'(o_rd_valid),  0);
        checkEq({tag, "_rd_data"},  32'(o_rd_data),   0);
        checkEq({tag, "_sat"},      32'(o_sat),       0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        quiet();
        sQuiet();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");

        // Release: sweep of exactly DEPTH cycles, then every bin reads 0.
        i_rst_n = 1'b1;
        countBusy(busyLen);
        checkEq("init_busy_len", 32'(busyLen), 128);
        checkEq("ready_after_sweep", 32'(o_acc_ready), 1);
        for (int b = 0; b < 128; b++) rd(b, 0);
        idle(); idle();

        // Four back-to-back hits on bin 3, then exact visibility timing.
        acc(3, 5); acc(3, 5); acc(3, 5); acc(3, 5);
        rd(3, 15);
        rd(3, 20);
        rd(2, 0);
        rd(4, 0);
        idle(); idle();

        // Alternate bins 7 and 8; read bin 7 during its last S1 write.
        for (int k = 0; k < 10; k++) begin
            if (k == 9) cyc(0, 1, 8, 255, 1, 7, 1020);
            else        cyc(0, 1, (k % 2 == 1) ? 8 : 7, 255, 0, 0, 0);
        end
        idle();
        rd(7, 1275);
        rd(8, 1275);
        idle(); idle();

        // Clear with bin 9 accumulating in S1 and another accepted in the clear cycle.
        acc(9, 40); acc(100, 77); idle(); idle();
        rd(9, 40); rd(100, 77); idle(); idle();
        acc(9, 7);
        cyc(1, 1, 9, 9, 0, 0, 0);
        countBusy(busyLen);
        checkEq("clear_busy_len", 32'(busyLen), 128);
        rd(9, 0); rd(100, 0); rd(3, 0); rd(7, 0); rd(8, 0);
        idle(); idle();

        // Reset in the middle of a sweep, after reading a not-yet-cleared bin.
        acc(100, 33); idle(); idle();
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (49) idle();
        rd(100, 33);
        quiet();
        @(negedge clk);
        checkEq("rd_valid_before_reset", 32'(o_rd_valid), 1);
        #1 i_rst_n = 1'b0;
        #1;
        checkResetOutputs("midsweep_reset");
        @(posedge clk); @(posedge clk); #1;
        i_rst_n = 1'b1;
        countBusy(busyLen);
        checkEq("resweep_busy_len", 32'(busyLen), 128);
        rd(100, 0); rd(50, 0); rd(127, 0);
        idle(); idle();

        // Small instance: overflow handling on an 8-bit sum.
        checkEq("small_ready", 32'(s_acc_ready), 1);
        sCyc(0, 1, 1, 200, 0, 0, 0);
        sCyc(0, 1, 1, 100, 0, 0, 0);
        sCyc(0, 0, 0, 0, 0, 0, 0);
        sCyc(0, 0, 0, 0, 1, 1, SMALL_SUM);
        sCyc(0, 0, 0, 0, 0, 0, 0);
        checkEq("small_sat", 32'(s_sat), SMALL_SAT);

        // Small instance: addresses at or above DEPTH are dropped and read as 0.
        sCyc(0, 1, 7, 50, 0, 0, 0);
        sCyc(0, 1, 6, 60, 0, 0, 0);
        sCyc(0, 0, 0, 0, 0, 0, 0);
        sCyc(0, 0, 0, 0, 1, 7, 0);
        sCyc(0, 0, 0, 0, 1, 6, 0);
        sCyc(0, 0, 0, 0, 1, 0, 0);
        sCyc(0, 0, 0, 0, 1, 1, SMALL_SUM);
        sCyc(0, 0, 0, 0, 0, 0, 0);
        sCyc(0, 0, 0, 0, 0, 0, 0);

        // Small instance: a sweep start drops the sticky flag and zeroes the bin.
        sCyc(1, 0, 0, 0, 0, 0, 0);
        sQuiet();
        @(negedge clk);
        checkEq("small_clear_busy", 32'(s_busy), 1);
        checkEq("small_clear_sat", 32'(s_sat), 0);
        for (int i = 0; i < 50 && s_busy; i++) @(negedge clk);
        checkEq("small_clear_done", 32'(s_busy), 0);
        @(posedge clk); #1;
        sCyc(0, 0, 0, 0, 1, 1, 0);
        sCyc(0, 0, 0, 0, 0, 0, 0);
        sCyc(0, 0, 0, 0, 0, 0, 0);

        checkEq("main_queue_drained", 32'(qMain.size()), 0);
        checkEq("small_queue_drained", 32'(qSmall.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_accum_sram.md
# sum_accum_sram

Parametrised accumulating bin memory for the time-frequency analyzer: each accepted sample magnitude is added into the addressed frequency bin by an internal read-modify-write pipeline. The block replaces plain write-only sum storage. It provides a second readout port for the display/counter side and a hardware clear sweep. It sits between the per-bin magnitude producers and the readout logic, all on one clock.

## Interface
- DATA_WIDTH, 8: width of each incoming unsigned sample.
- ACC_WIDTH, 16: width of each stored bin sum; must be at least DATA_WIDTH.
- ADDR_WIDTH, 7: bin address width.
- DEPTH, 128: number of bins; must be 2 or more and no more than 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clear  in  1  single-cycle request to zero all bins.
- o_busy  out  1  clear sweep in progress.
- i_acc_valid  in  1  accumulate request.
- o_acc_ready  out  1  accumulate request is accepted when i_acc_valid and o_acc_ready are both high.
- i_acc_addr  in  ADDR_WIDTH  bin to accumulate into.
- i_acc_data  in  DATA_WIDTH  unsigned value to add, zero-extended.
- i_rd_en  in  1  readout request.
- i_rd_addr  in  ADDR_WIDTH  bin to read.
- o_rd_valid  out  1  o_rd_data holds a result.
- o_rd_data  out  ACC_WIDTH  bin sum.
- o_sat  out  1  sticky saturation flag.

## Operation
- FSM states: CLEAR and RUN.
  - Reset enters CLEAR with sweep address 0.
  - CLEAR writes 0 to one bin per cycle, addresses 0 to DEPTH-1, then moves to RUN.
  - In RUN, a sampled i_clear moves the FSM to CLEAR with sweep address 0.
  - i_clear is ignored while in CLEAR.
- o_busy is high in CLEAR. o_acc_ready is the inverse of o_busy.
- Accumulate pipeline:
  - S0, the acceptance cycle: register the address and data, and read the bin.
  - S1: sum = old + data, written back to the bin.
  - One request can be accepted every cycle.
- Hazard rule: if the S0 address equals the S1 address, S0 uses the S1 sum instead of the stale RAM value. Back-to-back hits to the same bin must all be counted.
- Readout port:
  - Read-first: the data comes from the RAM array.
  - A bin written in the same cycle returns its pre-write value.
  - An accumulate still in S1 is not visible to readout until the following cycle.
  - i_rd_en is honoured in CLEAR too; it returns the partially cleared contents.
- Arithmetic: sum width is ACC_WIDTH. Overflow handling is set by the configuration macro.
- Addresses at or above DEPTH: accumulate requests are dropped (no write); reads return 0.

## Timing
- Reset values:
  - o_busy = 1, o_acc_ready = 0.
  - o_rd_valid = 0, o_rd_data = 0, o_sat = 0.
  - FSM = CLEAR, pipeline valid bits = 0.
  - RAM contents are not reset; the CLEAR sweep zeroes them.
- After i_rst_n deasserts: DEPTH cycles of clearing, then o_busy falls.
- i_clear sampled high in RUN:
  - o_busy rises the next cycle and stays high for DEPTH cycles.
  - An accumulate in S1 in the i_clear cycle completes its write; the sweep then overwrites it.
  - An accumulate accepted in the i_clear cycle is discarded.
- Readout latency: o_rd_valid and o_rd_data are registered one cycle after i_rd_en. o_rd_data holds its value when i_rd_en is low.
- Accumulate latency: a value accepted in cycle N is visible to a readout issued in cycle N+2.
- Reset asserted mid-sweep or mid-pipeline: all state returns immediately to the reset values, and the sweep restarts from 0.

## Configuration
- SUM_ACCUM_SAT_EN defined:
  - Sums clamp at 2^ACC_WIDTH-1.
  - Any clamp sets o_sat; o_sat is cleared only by reset or when a CLEAR sweep starts.
  - The forwarded value is the clamped value.
- SUM_ACCUM_SAT_EN undefined: sums wrap modulo 2^ACC_WIDTH, and o_sat is tied to 0.

## Structure
- Package sum_accum_pkg holds:
  - the FSM state enum (CLEAR, RUN);
  - a saturating-add function parameterised by width.
- Sub-module sum_accum_ram holds the storage:
  - simple dual-port array of DEPTH x ACC_WIDTH;
  - one synchronous read-first port shared by the S0 read and the S1/sweep write;
  - one synchronous readout port;
  - no reset on the array.
- Top level holds the FSM, sweep counter, S0/S1 registers, forwarding compare, and readout registers.

## Test plan
- Reset release, then poll reads -> o_busy high for exactly 128 cycles; every bin reads 0 afterwards.
- Accumulate 5 to bin 3 on four consecutive cycles -> bin 3 reads 20 at cycle N+2 after the last accept; bin 2 and bin 4 read 0.
- Alternate bins 7 and 8 every cycle with data 255 ten times, plus one read of bin 7 in the same cycle as its S1 write -> that read returns the pre-write value; final reads are 1275 each.
- With the macro defined, ACC_WIDTH=8, accumulate 200 then 100 to bin 1 -> bin 1 reads 255 and o_sat = 1. Without the macro -> bin 1 reads 44 and o_sat = 0.
- i_clear pulsed while bin 9 has an accumulate in flight -> o_busy for 128 cycles, and bin 9 reads 0 afterwards.
- Reset asserted at sweep address 50 -> outputs return to reset values at once; after release the sweep runs for the full 128 cycles.
